updown_mod_counter: RTL

- Parametrised successor to the team's fixed 4-bit free-running binary counter.
- Adds:
  - configurable width
  - up/down direction
  - runtime-programmable modulus
  - wrap or saturate mode
  - synchronous load
  - count enable
  - terminal-count pulse, sticky overflow flag and Gray-coded output
- Used as the general-purpose event/timer counter in datapath and control blocks.

---
 rtl/updown_mod_counter.sv | 82 ++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter for general event and timer counting.
// The legal range is 0..max_val, and max_val can be changed at runtime.
// At either bound the counter wraps or saturates (SATURATE), pulses tc
// and sets a sticky ovf flag. A synchronous load has priority over counting.
// A Gray-coded view of the count register is provided alongside the binary count.
module updown_mod_counter #(
    parameter int                   WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter bit                   SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    // Up bound uses >= so that lowering max_val below count still counts as a bound event
    logic at_top;
    logic at_bot;
    assign at_top = (count >= max_val);
    assign at_bot = (count == '0);

    // Next-state selection with priority load > en > hold
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf;
        if (load) begin
            count_nxt = (load_val > max_val) ? max_val : load_val;
            ovf_nxt   = 1'b0;
        end else if (en) begin
            if (up) begin
                if (!at_top) begin
                    count_nxt = count + 1'b1;
                end else begin
                    count_nxt = SATURATE ? max_val : '0;
                    tc_nxt    = 1'b1;
                    ovf_nxt   = 1'b1;
                end
            end else begin
                // A count above max_val (for example from RESET_VAL) still steps down normally
                if (!at_bot) begin
                    count_nxt = count - 1'b1;
                end else begin
                    count_nxt = SATURATE ? '0 : max_val;
                    tc_nxt    = 1'b1;
                    ovf_nxt   = 1'b1;
                end
            end
        end
    end

    // State registers; reset takes effect immediately, independent of clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Gray view is purely combinational from the count register
    always_comb begin
        gray = count ^ (count >> 1);
    end

endmodule
